// File: rtl/bird_physics_if.sv
// Signal bundle between the VGA timing/input side and the bird physics block.
// vsync and flap are plain level inputs; bird_x, bird_y and game_state are registered outputs.
interface bird_physics_if;
   logic       vsync;
   logic       flap;
   logic [9:0] bird_x;
   logic [9:0] bird_y;
   logic [1:0] game_state;

   modport master (
      output vsync,
      output flap,
      input  bird_x,
      input  bird_y,
      input  game_state
   );

   modport slave (
      input  vsync,
      input  flap,
      output bird_x,
      output bird_y,
      output game_state
   );
endinterface

// File: rtl/bird_physics.sv
// Frame-stepped vertical bird motion: gravity, flap impulse, ceiling clamp, floor death.
// One position/velocity step per vsync falling edge; game_state doubles as the FSM debug view.
module bird_physics #(
   parameter int BIRD_X   = 100,
   parameter int Y_START  = 230,
   parameter int Y_FLOOR  = 460,
   parameter int GRAVITY  = 1,
   parameter int FLAP_VEL = -8,
   parameter int VMAX     = 10
) (
   input logic           dclk,
   input logic           clr_n,
   bird_physics_if.slave vs
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PLAYING = 2'd1,
      ST_DEAD    = 2'd2
   } state_e;

   localparam logic        [9:0]  Y_START_V  = 10'(Y_START);
   localparam logic        [9:0]  Y_FLOOR_V  = 10'(Y_FLOOR);
   localparam logic signed [10:0] Y_FLOOR_11 = 11'(Y_FLOOR);
   localparam logic signed [5:0]  FLAP_V     = 6'(FLAP_VEL);
   localparam logic signed [6:0]  GRAV_7     = 7'(GRAVITY);
   localparam logic signed [6:0]  VMAX_7     = 7'(VMAX);

   state_e             state_q, state_d;
   logic        [9:0]  bird_y_q, bird_y_d;
   logic signed [5:0]  vel_q, vel_d;
   logic               pending_q, pending_d;
   logic               flap_s1_q, flap_s2_q, flap_prev_q;
   logic               vsync_dly_q;

   logic               flap_edge;
   logic               tick;
   logic               load_flap;
   logic signed [10:0] y_new;
   logic signed [6:0]  vel_inc;
   logic signed [5:0]  vel_grav;

   assign flap_edge = flap_s2_q & ~flap_prev_q;
   assign tick      = vsync_dly_q & ~vs.vsync;
   assign load_flap = pending_q | flap_edge;

   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         flap_s1_q   <= 1'b0;
         flap_s2_q   <= 1'b0;
         flap_prev_q <= 1'b0;
         vsync_dly_q <= 1'b1;
      end else begin
         flap_s1_q   <= vs.flap;
         flap_s2_q   <= flap_s1_q;
         flap_prev_q <= flap_s2_q;
         vsync_dly_q <= vs.vsync;
      end
   end

   // Arithmetic is widened so the ceiling test sees a true negative and vel+GRAVITY cannot wrap.
   always_comb begin
      y_new    = $signed({1'b0, bird_y_q}) + {{5{vel_q[5]}}, vel_q};
      vel_inc  = {vel_q[5], vel_q} + GRAV_7;
      vel_grav = (vel_inc > VMAX_7) ? VMAX_7[5:0] : vel_inc[5:0];
   end

   always_comb begin
      state_d   = state_q;
      bird_y_d  = bird_y_q;
      vel_d     = vel_q;
      pending_d = pending_q;
      unique case (state_q)
         ST_IDLE: begin
            bird_y_d = Y_START_V;
            vel_d    = '0;
            if (flap_edge) begin
               state_d   = ST_PLAYING;
               vel_d     = FLAP_V;
               pending_d = 1'b0;
            end
         end
         ST_PLAYING: begin
            if (tick) begin
               pending_d = 1'b0;
               if (y_new < 0) begin
                  bird_y_d = '0;
                  vel_d    = load_flap ? FLAP_V : 6'sd0;
               end else if (y_new >= Y_FLOOR_11) begin
                  bird_y_d = Y_FLOOR_V;
                  vel_d    = '0;
                  state_d  = ST_DEAD;
               end else begin
                  bird_y_d = y_new[9:0];
                  vel_d    = load_flap ? FLAP_V : vel_grav;
               end
            end else if (flap_edge) begin
               pending_d = 1'b1;
            end
         end
         ST_DEAD: begin
            if (flap_edge) begin
               state_d   = ST_IDLE;
               bird_y_d  = Y_START_V;
               vel_d     = '0;
               pending_d = 1'b0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bird_y_d  = Y_START_V;
            vel_d     = '0;
            pending_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= ST_IDLE;
         bird_y_q  <= Y_START_V;
         vel_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bird_y_q  <= bird_y_d;
         vel_q     <= vel_d;
         pending_q <= pending_d;
      end
   end

   assign vs.bird_x     = 10'(BIRD_X);
   assign vs.bird_y     = bird_y_q;
   assign vs.game_state = state_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: idle hold, flap climb, gravity fall to death,
// ceiling clamp, flap coalescing within a frame, and asynchronous reset mid-fall.
module tb_bird_physics;

   logic dclk;
   logic clr_n;
   int   errors;
   int   checks;
   logic [9:0] exp_q[$];

   bird_physics_if bif ();

   bird_physics dut (
      .dclk  (dclk),
      .clr_n (clr_n),
      .vs    (bif)
   );

   // 25 MHz pixel clock
   initial begin
      dclk = 1'b0;
      forever #20 dclk = ~dclk;
   end

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_frame();
      @(negedge dclk) bif.vsync = 1'b0;
      repeat (2) @(negedge dclk);
      bif.vsync = 1'b1;
      repeat (3) @(negedge dclk);
   endtask

   task automatic do_flap();
      @(negedge dclk) bif.flap = 1'b1;
      repeat (4) @(negedge dclk);
      bif.flap = 1'b0;
      repeat (4) @(negedge dclk);
   endtask

   task automatic do_reset();
      @(negedge dclk) clr_n = 1'b0;
      repeat (2) @(negedge dclk);
      clr_n = 1'b1;
      repeat (2) @(negedge dclk);
   endtask

   task automatic frame_check_y(input string tag);
      logic [9:0] e;
      do_frame();
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: expected queue empty", tag);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, {6'd0, bif.bird_y}, {6'd0, e});
      end
   endtask

   // Hand-computed positions after each tick starting from a flap at y=230
   logic [9:0] fall_tbl [19] = '{222, 215, 209, 204, 200, 197, 195, 194, 194, 195,
                                 197, 200, 204, 209, 215, 222, 230, 239, 249};

   initial begin
      errors    = 0;
      checks    = 0;
      clr_n     = 1'b0;
      bif.vsync = 1'b1;
      bif.flap  = 1'b0;
      repeat (3) @(negedge dclk);
      check_val("rst_bird_x", {6'd0, bif.bird_x}, 16'd100);
      check_val("rst_bird_y", {6'd0, bif.bird_y}, 16'd230);
      check_val("rst_state", {14'd0, bif.game_state}, 16'd0);
      clr_n = 1'b1;
      repeat (2) @(negedge dclk);

      for (int i = 0; i < 5; i++) begin
         do_frame();
         check_val("idle_hold_y", {6'd0, bif.bird_y}, 16'd230);
      end
      check_val("idle_hold_state", {14'd0, bif.game_state}, 16'd0);

      do_flap();
      check_val("start_state", {14'd0, bif.game_state}, 16'd1);
      check_val("start_y", {6'd0, bif.bird_y}, 16'd230);
      exp_q.push_back(10'd222);
      exp_q.push_back(10'd215);
      exp_q.push_back(10'd209);
      exp_q.push_back(10'd204);
      for (int i = 0; i < 4; i++) frame_check_y("climb_y");

      // Two presses in one frame must load FLAP_VEL once, then gravity resumes.
      do_flap();
      do_flap();
      exp_q.push_back(10'd200);
      exp_q.push_back(10'd192);
      exp_q.push_back(10'd185);
      for (int i = 0; i < 3; i++) frame_check_y("dbl_flap_y");
      check_val("dbl_flap_state", {14'd0, bif.game_state}, 16'd1);

      do_reset();
      do_flap();
      for (int k = 0; k < 19; k++) exp_q.push_back(fall_tbl[k]);
      for (int k = 20; k <= 40; k++) exp_q.push_back(10'(249 + 10 * (k - 19)));
      for (int k = 1; k <= 40; k++) frame_check_y("fall_y");
      check_val("fall_state", {14'd0, bif.game_state}, 16'd1);
      do_frame();
      check_val("floor_y", {6'd0, bif.bird_y}, 16'd460);
      check_val("floor_state", {14'd0, bif.game_state}, 16'd2);
      for (int i = 0; i < 3; i++) begin
         do_frame();
         check_val("dead_frozen_y", {6'd0, bif.bird_y}, 16'd460);
         check_val("dead_frozen_state", {14'd0, bif.game_state}, 16'd2);
      end
      do_flap();
      check_val("revive_state", {14'd0, bif.game_state}, 16'd0);
      check_val("revive_y", {6'd0, bif.bird_y}, 16'd230);

      // Flap every frame: y drops by 8 per tick until it crosses the ceiling.
      do_flap();
      for (int k = 1; k <= 29; k++) begin
         do_flap();
         do_frame();
         if (k == 28) check_val("ceil_pre_y", {6'd0, bif.bird_y}, 16'd6);
      end
      check_val("ceil_clamp_y", {6'd0, bif.bird_y}, 16'd0);
      check_val("ceil_state", {14'd0, bif.game_state}, 16'd1);
      exp_q.push_back(10'd0);
      exp_q.push_back(10'd0);
      exp_q.push_back(10'd1);
      for (int i = 0; i < 3; i++) frame_check_y("ceil_release_y");
      check_val("ceil_release_state", {14'd0, bif.game_state}, 16'd1);

      do_reset();
      do_flap();
      for (int k = 1; k <= 24; k++) do_frame();
      check_val("midfall_y", {6'd0, bif.bird_y}, 16'd299);
      @(negedge dclk);
      bif.vsync = 1'b0;
      clr_n     = 1'b0;
      #1;
      check_val("async_rst_y", {6'd0, bif.bird_y}, 16'd230);
      check_val("async_rst_state", {14'd0, bif.game_state}, 16'd0);
      @(posedge dclk);
      #1;
      check_val("rst_held_y", {6'd0, bif.bird_y}, 16'd230);
      @(negedge dclk) clr_n = 1'b1;
      repeat (2) @(negedge dclk);
      bif.vsync = 1'b1;
      repeat (2) @(negedge dclk);
      check_val("post_rst_y", {6'd0, bif.bird_y}, 16'd230);
      check_val("post_rst_state", {14'd0, bif.game_state}, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
